// File: rtl/pipe_stage_reg_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared defaults and the payload type for inter-stage pipeline registers.
//   DEF_PC_W / DEF_INST_W   : default field widths
//   DEF_RST_PC              : pc shown on the stage output after reset
//   DEF_NOP_INST            : payload shown whenever the stage holds nothing
//   pipe_word_t             : {pc, inst} payload at default widths
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int          DEF_PC_W     = 32;
    localparam int          DEF_INST_W   = 32;
    localparam logic [31:0] DEF_RST_PC   = 32'h8000_0000;
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_INST_W-1:0] inst;
    } pipe_word_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
// Valid/ready handshake carrying one {pc, inst} word between pipeline stages.
//   valid : producer has a word
//   ready : consumer takes the word this cycle (when valid)
//   pc    : word pc
//   inst  : word instruction / payload
// Modports: master = producer side, slave = consumer side.
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W
);

    logic              valid;
    logic              ready;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;

    modport master (
        output valid,
        output pc,
        output inst,
        input  ready
    );

    modport slave (
        input  valid,
        input  pc,
        input  inst,
        output ready
    );

endinterface

// File: rtl/pipe_stage_reg_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry FIFO storage for a pipeline stage. Slot p0 is the head that the
// downstream stage sees; slot p1 catches the word that arrives while the head
// is blocked. Enqueue/dequeue arrive already gated by the parent, so this
// block only tracks occupancy and moves words.
//   clk, rst        : clock, synchronous active-high reset
//   flush           : empty the buffer (head pc is kept)
//   i_enq / i_deq   : accept a word / retire the head this cycle
//   i_pc / i_inst   : incoming word
//   o_pc / o_inst   : head word
//   o_count         : occupancy 0..2
//   o_full          : two words held; depends on registered state only
// -----------------------------------------------------------------------------
module pipe_skid_buf
    import pipe_pkg::*;
#(
    parameter int              PC_W   = DEF_PC_W,
    parameter int              INST_W = DEF_INST_W,
    parameter logic [PC_W-1:0] RST_PC = PC_W'(DEF_RST_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_enq,
    input  logic              i_deq,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [INST_W-1:0] i_inst,
    output logic [PC_W-1:0]   o_pc,
    output logic [INST_W-1:0] o_inst,
    output logic [1:0]        o_count,
    output logic              o_full
);

    logic [1:0]        r_count;
    logic [PC_W-1:0]   r_pc_p0;
    logic [INST_W-1:0] r_inst_p0;
    logic [PC_W-1:0]   r_pc_p1;
    logic [INST_W-1:0] r_inst_p1;

    logic w_load_head;
    logic w_load_tail;
    logic w_shift;

    // Incoming word goes straight to the head when the buffer is empty, or
    // when the current sole head leaves in the same cycle.
    assign w_load_head = i_enq & ((r_count == 2'd0) | ((r_count == 2'd1) & i_deq));
    assign w_load_tail = i_enq & (r_count == 2'd1) & !i_deq;
    assign w_shift     = i_deq & (r_count == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 2'd0;
        end else if (flush) begin
            r_count <= 2'd0;
        end else begin
            case (r_count)
                2'd0:    if (i_enq) r_count <= 2'd1;
                2'd1:    if (i_enq && !i_deq) r_count <= 2'd2;
                         else if (!i_enq && i_deq) r_count <= 2'd0;
                2'd2:    if (i_deq) r_count <= 2'd1;
                default: r_count <= 2'd0;
            endcase
        end
    end

    // --- slot p0 (head) / slot p1 (skid) ---
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_p0 <= RST_PC;
        end else if (!flush) begin
            if (w_load_head) begin
                r_pc_p0   <= i_pc;
                r_inst_p0 <= i_inst;
            end else if (w_shift) begin
                r_pc_p0   <= r_pc_p1;
                r_inst_p0 <= r_inst_p1;
            end
            if (w_load_tail) begin
                r_pc_p1   <= i_pc;
                r_inst_p1 <= i_inst;
            end
        end
    end

    assign o_pc    = r_pc_p0;
    assign o_inst  = r_inst_p0;
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic inter-stage pipeline register carrying {pc, inst} with valid/ready
// handshake, hazard stall, flush and an optional 2-entry skid buffer.
//   clk, rst : clock, synchronous active-high reset
//   stall    : freeze; nothing enters or leaves this cycle
//   flush    : drop every held word; the word offered this cycle is refused
//   up       : upstream side (valid/pc/inst in, ready out)
//   dn       : downstream side (valid/pc/inst out, ready in)
//   count    : occupancy (0..1 with SKID=0, 0..2 with SKID=1)
// SKID=0 keeps one register and its ready follows dn.ready combinationally;
// SKID=1 uses pipe_skid_buf so up.ready comes from registered state only.
// dn.inst shows NOP_INST whenever dn.valid is low; dn.pc keeps the last head.
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                PC_W     = DEF_PC_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0]   RST_PC   = PC_W'(DEF_RST_PC),
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(DEF_NOP_INST),
    parameter bit                SKID     = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    flush,
    pipe_stage_reg_if.slave         up,
    pipe_stage_reg_if.master        dn,
    output logic [1:0]              count
);

    logic              w_enq;
    logic              w_deq;
    logic              w_in_ready;
    logic              w_head_valid;
    logic [PC_W-1:0]   w_head_pc;
    logic [INST_W-1:0] w_head_inst;
    logic [1:0]        w_count;

    assign w_enq        = up.valid & w_in_ready;
    assign w_deq        = w_head_valid & dn.ready & !stall & !flush;
    assign w_head_valid = (w_count != 2'd0);

    generate
        if (SKID) begin : g_skid
            logic w_full;

            pipe_skid_buf #(
                .PC_W   (PC_W),
                .INST_W (INST_W),
                .RST_PC (RST_PC)
            ) u_skid_buf (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .i_enq   (w_enq),
                .i_deq   (w_deq),
                .i_pc    (up.pc),
                .i_inst  (up.inst),
                .o_pc    (w_head_pc),
                .o_inst  (w_head_inst),
                .o_count (w_count),
                .o_full  (w_full)
            );

            assign w_in_ready = !stall & !flush & !w_full;
        end else begin : g_single
            logic              r_vld_p0;
            logic [PC_W-1:0]   r_pc_p0;
            logic [INST_W-1:0] r_inst_p0;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_vld_p0 <= 1'b0;
                end else if (flush) begin
                    r_vld_p0 <= 1'b0;
                end else if (w_enq) begin
                    r_vld_p0 <= 1'b1;
                end else if (w_deq) begin
                    r_vld_p0 <= 1'b0;
                end
            end

            // --- head register p0 ---
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pc_p0 <= RST_PC;
                end else if (w_enq) begin
                    r_pc_p0   <= up.pc;
                    r_inst_p0 <= up.inst;
                end
            end

            assign w_count     = {1'b0, r_vld_p0};
            assign w_head_pc   = r_pc_p0;
            assign w_head_inst = r_inst_p0;
            // The head may be replaced in the same cycle it is consumed.
            assign w_in_ready  = !stall & !flush & (!r_vld_p0 | dn.ready);
        end
    endgenerate

    assign up.ready = w_in_ready;
    assign dn.valid = w_head_valid;
    assign dn.pc    = w_head_pc;
    assign dn.inst  = w_head_valid ? w_head_inst : NOP_INST;
    assign count    = w_count;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised successor to the fixed IF/ID register: a generic inter-stage pipeline register carrying {pc, inst} with a valid/ready handshake, an external hazard stall, flush, and an optional 2-entry skid buffer. It is instantiated between any two adjacent stages (IF/ID, ID/EX, ...). Downstream backpressure does not need a combinational ready path through the whole pipe.

Parameters:
PC_W, 32, width of the pc field
INST_W, 32, width of the instruction/payload field
RST_PC, 32'h8000_0000, pc value presented on out_pc after reset
NOP_INST, 0, payload presented on out_inst whenever out_valid=0
SKID, 1, 0 = single register (combinational ready); 1 = 2-entry skid buffer (registered ready)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard freeze: no enqueue, no dequeue this cycle
flush  in  1  discard all held entries (branch/exception)
in_valid  in  1  upstream has a word
in_ready  out  1  this stage accepts a word this cycle
in_pc  in  PC_W  upstream pc
in_inst  in  INST_W  upstream instruction
out_valid  out  1  head entry valid
out_ready  in  1  downstream consumes head this cycle
out_pc  out  PC_W  head pc
out_inst  out  INST_W  head instruction, NOP_INST when out_valid=0
count  out  2  occupancy (0..1 when SKID=0, 0..2 when SKID=1)

Behaviour:
- Clocking/reset: one clock, clk; reset rst is synchronous and active-high. Reset values: count=0, out_valid=0, out_pc=RST_PC, out_inst=NOP_INST. Reset overrides flush, stall and every handshake.
- enq = in_valid & in_ready. deq = out_valid & out_ready & !stall & !flush.
- Priority: rst > flush > stall > normal operation.
- flush=1: next cycle count=0 and out_valid=0. in_ready=0 during the flush cycle, so a word offered in the same cycle is dropped. out_pc holds its last value.
- stall=1 (flush=0): in_ready=0. All state holds. out_valid/out_pc/out_inst stay stable, and downstream must not treat the head as consumed.
- SKID=0: in_ready = !stall & !flush & (!out_valid | out_ready). On enq, the head loads {in_pc,in_inst} next cycle and out_valid=1. On deq without enq, out_valid=0. Latency is 1 cycle.
- SKID=1: 2-entry FIFO, head at out_*. in_ready = !stall & !flush & (count<2), and depends on registered count only (plus stall/flush).
  - count 0, enq: next cycle count=1, head=new word. Latency is 1 cycle.
  - count 1, enq & deq: count stays 1 and the head is replaced by the new word.
  - count 1, enq only: count becomes 2 and the word goes to the second slot.
  - count 2: in_ready=0. On deq, the second slot moves to the head and count=1.
  - Strict FIFO order. No word is duplicated or lost except by flush or rst.
- out_inst = NOP_INST whenever out_valid=0. out_pc always shows the last head pc (RST_PC after reset).
- Reset mid-operation: buffered words are discarded with no partial transfer. Inputs in the reset cycle are ignored.

Decomposition:
- Shared package pipe_pkg: DEF_PC_W, DEF_INST_W, DEF_RST_PC (32'h8000_0000), DEF_NOP_INST (32'h0), and a struct type {pc, inst} for stage payloads.
- One natural sub-module: pipe_skid_buf (2-entry storage plus count/ready logic), generated only when SKID=1. The top level handles stall/flush gating and the NOP substitution on out_inst.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 -> out_valid=0, out_pc=32'h8000_0000, out_inst=0, count=0.
- Stream, SKID=1: send pc 0x80000000/0x80000004/0x80000008 with out_ready=1 -> each word appears 1 cycle after acceptance, in order, count never exceeds 1.
- Backpressure, SKID=1: out_ready=0, offer 3 words -> first two accepted (count=2), in_ready=0 on the third. Then raise out_ready -> words drain in order, third accepted after the first deq.
- Stall: with count=1 (head pc 0x80000010), hold stall=1 for 3 cycles with in_valid=1 and out_ready=1 -> in_ready=0, head unchanged, count=1. After release, head dequeues and the new word follows.
- Flush: count=2 plus in_valid=1 in the flush cycle -> next cycle count=0, out_valid=0, out_inst=0, offered word dropped.
- SKID=0: out_ready=0 with head valid -> in_ready=0 combinationally. Set out_ready=1 in the same cycle -> in_ready=1, head replaced next cycle.
